// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage. Takes one EXE result per cycle while idle and
// either forwards it straight to write-back (non-memory op), or performs a
// single load/store on the data-memory port and stalls upstream until the
// memory acknowledges or a timeout expires. Misaligned or contradictory
// accesses are rejected without touching memory.
//
// Parameters
//   WORD_LEN  datapath width
//   TIMEOUT   max BUSY cycles without dmem_ack before the access is aborted
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   valid_in                 EXE result present (ignored while BUSY)
//   ALU_Result_in            EXE result / memory address
//   Store_Value_in           store data
//   Dest_in, WB_EN_in        write-back destination and enable
//   MEM_R_EN_in, MEM_W_EN_in load / store request
//   dmem_req/we/addr/wdata   registered data-memory request, stable in BUSY
//   dmem_rdata, dmem_ack     data-memory response
//   mem_stall                high exactly while BUSY
//   ALU_Result_MEM           captured ALU result (forwarding path)
//   WB_valid, WB_EN, Dest,
//   MEM_Result               one-cycle write-back pulse and its payload
//   mem_err                  sticky error (misalignment, conflict, timeout)
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int WORD_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [WORD_LEN-1:0] ALU_Result_in,
  input  logic [WORD_LEN-1:0] Store_Value_in,
  input  logic [4:0]          Dest_in,
  input  logic                WB_EN_in,
  input  logic                MEM_R_EN_in,
  input  logic                MEM_W_EN_in,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD_LEN-1:0] dmem_addr,
  output logic [WORD_LEN-1:0] dmem_wdata,
  input  logic [WORD_LEN-1:0] dmem_rdata,
  input  logic                dmem_ack,
  output logic                mem_stall,
  output logic [WORD_LEN-1:0] ALU_Result_MEM,
  output logic                WB_valid,
  output logic                WB_EN,
  output logic [4:0]          Dest,
  output logic [WORD_LEN-1:0] MEM_Result,
  output logic                mem_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter is compared with one extra bit so TIMEOUT = 255 is reachable.
  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t              state_q,    state_d;
  logic [7:0]          cnt_q,      cnt_d;
  logic                req_q,      req_d;
  logic                we_q,       we_d;
  logic [WORD_LEN-1:0] addr_q,     addr_d;
  logic [WORD_LEN-1:0] wdata_q,    wdata_d;
  logic [WORD_LEN-1:0] alu_q,      alu_d;
  logic [4:0]          dest_q,     dest_d;
  logic                wben_req_q, wben_req_d;  // WB_EN_in of the access in flight
  logic                wb_valid_q, wb_valid_d;
  logic                wb_en_q,    wb_en_d;
  logic [WORD_LEN-1:0] result_q,   result_d;
  logic                err_q,      err_d;

  logic       is_mem;
  logic       bad_access;
  logic       ack_seen;
  logic [8:0] cnt_inc;

  assign is_mem     = MEM_R_EN_in | MEM_W_EN_in;
  // Both enables at once, or a non word-aligned address, is rejected.
  assign bad_access = (MEM_R_EN_in & MEM_W_EN_in) | (ALU_Result_in[1:0] != 2'b00);
  // Acknowledge only counts while a request is actually outstanding.
  assign ack_seen   = req_q & dmem_ack;
  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    alu_d      = alu_q;
    dest_d     = dest_q;
    wben_req_d = wben_req_q;
    wb_valid_d = 1'b0;          // write-back is always a single-cycle pulse
    wb_en_d    = wb_en_q;
    result_d   = result_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          alu_d      = ALU_Result_in;
          dest_d     = Dest_in;
          wben_req_d = WB_EN_in;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_en_d    = WB_EN_in;
            result_d   = ALU_Result_in;
          end else if (bad_access) begin
            wb_valid_d = 1'b1;
            wb_en_d    = 1'b0;
            err_d      = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = MEM_W_EN_in;
            addr_d  = ALU_Result_in;
            wdata_d = Store_Value_in;
          end
        end
      end

      BUSY: begin
        if (ack_seen) begin
          // Completion takes priority over a timeout on the same edge.
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          if (we_q) begin
            wb_en_d = 1'b0;
          end else begin
            wb_en_d  = wben_req_q;
            result_d = dmem_rdata;
          end
        end else if (cnt_inc >= TO_LIM) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_en_d    = 1'b0;
          err_d      = 1'b1;
          cnt_d      = cnt_inc[7:0];
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      alu_q      <= '0;
      dest_q     <= 5'd0;
      wben_req_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      alu_q      <= alu_d;
      dest_q     <= dest_d;
      wben_req_q <= wben_req_d;
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      result_q   <= result_d;
      err_q      <= err_d;
    end
  end

  assign mem_stall      = (state_q == BUSY);
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign ALU_Result_MEM = alu_q;
  assign WB_valid       = wb_valid_q;
  assign WB_EN          = wb_en_q;
  assign Dest           = dest_q;
  assign MEM_Result     = result_q;
  assign mem_err        = err_q;

endmodule
